// File: rtl/di_pkg.sv
// Shared DI register-bus definitions: FSM state encoding, status codes, bus widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package di_pkg;

  localparam int DI_TERM_W   = 16;
  localparam int DI_ADDR_W   = 32;
  localparam int DI_DATA_W   = 32;
  localparam int DI_STATUS_W = 16;

  localparam logic [DI_STATUS_W-1:0] DI_STATUS_OK      = 16'h0000;
  localparam logic [DI_STATUS_W-1:0] DI_STATUS_TIMEOUT = 16'hFFFF;
  localparam logic [DI_STATUS_W-1:0] DI_STATUS_NOTERM  = 16'hFFFE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_XFER,
    ST_WR_DATA,
    ST_WR_WAIT,
    ST_WR_XFER,
    ST_RESP
  } di_state_e;

endpackage

// File: rtl/di_host_master_if.sv
// Host command/write/response streams plus the DI terminal-side bus, bundled as one interface.
// Latency: n/a (wires only).
// Backpressure: valid/ready on cmd, wr and rsp; terminals stall via di_read_rdy/di_write_rdy.
// Modports: master = di_host_master view; slave = host transport + terminal view.
interface di_host_master_if
  import di_pkg::*;
#(
  parameter int LEN_WIDTH = 8
);

  // host command stream
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_write;
  logic [DI_TERM_W-1:0]   cmd_term;
  logic [DI_ADDR_W-1:0]   cmd_addr;
  logic [LEN_WIDTH-1:0]   cmd_len;
  // host write-data stream
  logic                   wr_valid;
  logic                   wr_ready;
  logic [DI_DATA_W-1:0]   wr_data;
  // host response stream
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [DI_DATA_W-1:0]   rsp_rdata;
  logic [DI_STATUS_W-1:0] rsp_status;
  logic                   rsp_last;
  // terminal side
  logic [DI_TERM_W-1:0]   di_term_addr;
  logic [DI_ADDR_W-1:0]   di_reg_addr;
  logic                   di_read_mode;
  logic                   di_read_req;
  logic                   di_read;
  logic                   di_write_mode;
  logic                   di_write;
  logic [DI_DATA_W-1:0]   di_reg_datai;
  logic                   di_read_rdy;
  logic                   di_write_rdy;
  logic                   di_en;
  logic [DI_DATA_W-1:0]   di_reg_datao;
  logic [DI_STATUS_W-1:0] di_transfer_status;

  modport master (
    input  cmd_valid, cmd_write, cmd_term, cmd_addr, cmd_len,
    output cmd_ready,
    input  wr_valid, wr_data,
    output wr_ready,
    output rsp_valid, rsp_rdata, rsp_status, rsp_last,
    input  rsp_ready,
    output di_term_addr, di_reg_addr, di_read_mode, di_read_req, di_read,
    output di_write_mode, di_write, di_reg_datai,
    input  di_read_rdy, di_write_rdy, di_en, di_reg_datao, di_transfer_status
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_term, cmd_addr, cmd_len,
    input  cmd_ready,
    output wr_valid, wr_data,
    input  wr_ready,
    input  rsp_valid, rsp_rdata, rsp_status, rsp_last,
    output rsp_ready,
    input  di_term_addr, di_reg_addr, di_read_mode, di_read_req, di_read,
    input  di_write_mode, di_write, di_reg_datai,
    output di_read_rdy, di_write_rdy, di_en, di_reg_datao, di_transfer_status
  );

endinterface

// File: rtl/di_timeout_counter.sv
// Per-word wait watchdog: counts cycles while enabled, flags the last allowed cycle.
// Latency: expired is combinational in the TIMEOUT_CYCLES-th enabled cycle after a clear.
// Backpressure: none.
// Ports: di_clk, resetb (async active-low), clr (sync clear), en (count), expired.
module di_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_WIDTH       = 11
) (
  input  logic di_clk,
  input  logic resetb,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TO_WIDTH-1:0] cnt_q;

  always_ff @(posedge di_clk or negedge resetb) begin
    if (!resetb) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + TO_WIDTH'(1);
    end
  end

  // cnt_q holds the number of cycles already spent waiting, so the cycle in
  // which it reads TIMEOUT_CYCLES-1 is the last one; the waiter leaves after it.
  assign expired = en && (cnt_q == TO_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/di_host_master.sv
// DI bus initiator: turns host single/burst register commands into di_* transactions, one response per word.
// Latency: accept -> rsp_valid 4 cycles per read word with terminal ready; writes add wr_data wait.
// Backpressure: holds in RESP with stable rsp_* until rsp_ready; stalls on di_*_rdy up to TIMEOUT_CYCLES.
// Ports: di_clk, resetb (async active-low), bus (di_host_master_if.master: cmd/wr/rsp streams + di_* bus).
module di_host_master
  import di_pkg::*;
#(
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_WIDTH       = 11
) (
  input  logic             di_clk,
  input  logic             resetb,
  di_host_master_if.master bus
);

  di_state_e              state_q, state_d;
  logic                   run_q;        // keeps cmd_ready low while in reset
  logic                   is_write_q;
  logic                   mode_q;
  logic [LEN_WIDTH-1:0]   remain_q;     // words left after the current one
  logic [DI_TERM_W-1:0]   term_q;
  logic [DI_ADDR_W-1:0]   addr_q;
  logic [DI_DATA_W-1:0]   datai_q;
  logic [DI_DATA_W-1:0]   rsp_rdata_q;
  logic [DI_STATUS_W-1:0] rsp_status_q;
  logic                   rsp_last_q;

  logic                   cmd_rdy, cmd_acc, wr_acc, rsp_acc;
  logic                   in_wait, wait_rdy, to_expired;
  logic                   resp_load;
  logic [DI_DATA_W-1:0]   resp_rdata_d;
  logic [DI_STATUS_W-1:0] resp_status_d;

  assign cmd_rdy  = run_q && (state_q == ST_IDLE);
  assign cmd_acc  = cmd_rdy && bus.cmd_valid;
  assign wr_acc   = (state_q == ST_WR_DATA) && bus.wr_valid;
  assign rsp_acc  = (state_q == ST_RESP) && bus.rsp_ready;
  assign in_wait  = (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);
  assign wait_rdy = (state_q == ST_RD_WAIT) ? bus.di_read_rdy : bus.di_write_rdy;

  // Cleared whenever we are outside a wait state, so every wait starts from zero.
  di_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_WIDTH       (TO_WIDTH)
  ) u_timeout (
    .di_clk  (di_clk),
    .resetb  (resetb),
    .clr     (!in_wait),
    .en      (in_wait),
    .expired (to_expired)
  );

  always_ff @(posedge di_clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    resp_load     = 1'b0;
    resp_rdata_d  = '0;
    resp_status_d = DI_STATUS_OK;
    case (state_q)
      ST_IDLE: begin
        if (cmd_acc) begin
          state_d = bus.cmd_write ? ST_WR_DATA : ST_RD_REQ;
        end
      end
      ST_RD_REQ: state_d = ST_RD_WAIT;
      ST_WR_DATA: begin
        if (wr_acc) begin
          state_d = ST_WR_WAIT;
        end
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        // An absent terminal wins over ready/timeout so no strobe ever reaches it.
        if (!bus.di_en) begin
          state_d       = ST_RESP;
          resp_load     = 1'b1;
          resp_status_d = DI_STATUS_NOTERM;
        end else if (wait_rdy) begin
          state_d = (state_q == ST_RD_WAIT) ? ST_RD_XFER : ST_WR_XFER;
        end else if (to_expired) begin
          state_d       = ST_RESP;
          resp_load     = 1'b1;
          resp_status_d = DI_STATUS_TIMEOUT;
        end
      end
      ST_RD_XFER: begin
        state_d       = ST_RESP;
        resp_load     = 1'b1;
        resp_rdata_d  = bus.di_reg_datao;
        resp_status_d = bus.di_transfer_status;
      end
      ST_WR_XFER: begin
        state_d       = ST_RESP;
        resp_load     = 1'b1;
        resp_status_d = bus.di_transfer_status;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          if (rsp_last_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = is_write_q ? ST_WR_DATA : ST_RD_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge di_clk or negedge resetb) begin
    if (!resetb) begin
      run_q        <= 1'b0;
      is_write_q   <= 1'b0;
      mode_q       <= 1'b0;
      remain_q     <= '0;
      term_q       <= '0;
      addr_q       <= '0;
      datai_q      <= '0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= '0;
      rsp_last_q   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (cmd_acc) begin
        is_write_q <= bus.cmd_write;
        mode_q     <= 1'b1;
        remain_q   <= bus.cmd_len;
        term_q     <= bus.cmd_term;
        addr_q     <= bus.cmd_addr;
      end
      if (wr_acc) begin
        datai_q <= bus.wr_data;
      end
      if (resp_load) begin
        rsp_rdata_q  <= resp_rdata_d;
        rsp_status_q <= resp_status_d;
        // Any non-zero status ends the burst early and is reported as the last word.
        rsp_last_q   <= (remain_q == '0) || (resp_status_d != DI_STATUS_OK);
      end
      if (rsp_acc) begin
        if (rsp_last_q) begin
          mode_q <= 1'b0;
        end else begin
          addr_q   <= addr_q + 32'd1;  // natural wrap FFFFFFFF -> 0
          remain_q <= remain_q - LEN_WIDTH'(1);
        end
      end
    end
  end

  assign bus.cmd_ready     = cmd_rdy;
  assign bus.wr_ready      = (state_q == ST_WR_DATA);
  assign bus.rsp_valid     = (state_q == ST_RESP);
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.rsp_status    = rsp_status_q;
  assign bus.rsp_last      = rsp_last_q;
  assign bus.di_term_addr  = term_q;
  assign bus.di_reg_addr   = addr_q;
  assign bus.di_read_mode  = mode_q && !is_write_q;
  assign bus.di_write_mode = mode_q && is_write_q;
  assign bus.di_read_req   = (state_q == ST_RD_REQ);
  assign bus.di_read       = (state_q == ST_RD_XFER);
  assign bus.di_write      = (state_q == ST_WR_XFER);
  assign bus.di_reg_datai  = datai_q;

endmodule

// File: tb/tb_di_host_master.sv
// Directed bench for di_host_master with a response scoreboard and a simple terminal model.
// Latency: n/a.
// Backpressure: bench holds rsp_ready low and gaps wr_valid in the backpressure step.
`timescale 1ns/1ps
module tb_di_host_master;
  import di_pkg::*;

  localparam int LEN_WIDTH      = 8;
  localparam int TIMEOUT_CYCLES = 1024;
  localparam int TO_WIDTH       = 11;
  localparam logic [15:0] DOT_TERM = 16'h0010;

  typedef struct packed {
    logic [31:0] rdata;
    logic [15:0] status;
    logic        last;
  } rsp_t;

  logic di_clk = 1'b0;
  logic resetb = 1'b0;
  always #5 di_clk = ~di_clk;

  di_host_master_if #(.LEN_WIDTH(LEN_WIDTH)) bus ();

  di_host_master #(
    .LEN_WIDTH      (LEN_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_WIDTH       (TO_WIDTH)
  ) dut (
    .di_clk (di_clk),
    .resetb (resetb),
    .bus    (bus)
  );

  // Terminal model: DotProductTest at DOT_TERM answers rdata = address*2.
  logic        rd_rdy, wr_rdy;
  logic [15:0] term_status;
  assign bus.di_read_rdy        = rd_rdy;
  assign bus.di_write_rdy       = wr_rdy;
  assign bus.di_en              = (bus.di_term_addr == DOT_TERM);
  assign bus.di_reg_datao       = bus.di_reg_addr << 1;
  assign bus.di_transfer_status = term_status;

  int checks, failures;
  int cyc, acc_cyc, lat;
  int rd_cnt, wr_cnt, req_cnt, both_cnt;
  logic [31:0] req_addr_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_dat_q[$];
  rsp_t sb[$];

  always @(posedge di_clk) cyc++;

  always @(negedge di_clk) begin
    if (bus.di_read_req) begin req_cnt++; req_addr_q.push_back(bus.di_reg_addr); end
    if (bus.di_read) rd_cnt++;
    if (bus.di_write) begin
      wr_cnt++;
      wr_addr_q.push_back(bus.di_reg_addr);
      wr_dat_q.push_back(bus.di_reg_datai);
    end
    if (bus.di_read && bus.di_write) both_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    rd_cnt = 0; wr_cnt = 0; req_cnt = 0;
    req_addr_q.delete(); wr_addr_q.delete(); wr_dat_q.delete();
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_cmd(input logic wr, input logic [15:0] term, input logic [31:0] addr,
                          input logic [7:0] len);
    int n = 0;
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_term = term;
    bus.cmd_addr = addr; bus.cmd_len = len;
    while (!bus.cmd_ready && n < 50) begin @(negedge di_clk); n++; end
    chk("cmd_accept", 32'(bus.cmd_ready), 1);
    acc_cyc = cyc;
    @(negedge di_clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input int hold);
    int   n = 0;
    int   strobes;
    logic stable;
    rsp_t e, snap;
    while (!bus.rsp_valid && n < TIMEOUT_CYCLES + 100) begin @(negedge di_clk); n++; end
    chk("rsp_arrive", 32'(bus.rsp_valid), 1);
    lat = cyc - acc_cyc;
    chk("sb_pending", 32'(sb.size() > 0), 1);
    if (sb.size() > 0) e = sb.pop_front(); else e = '1;
    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
    chk("rsp_status", 32'(bus.rsp_status), 32'(e.status));
    chk("rsp_last", 32'(bus.rsp_last), 32'(e.last));
    snap    = {bus.rsp_rdata, bus.rsp_status, bus.rsp_last};
    strobes = rd_cnt + wr_cnt;
    stable  = 1'b1;
    repeat (hold) begin
      @(negedge di_clk);
      if (!bus.rsp_valid || ({bus.rsp_rdata, bus.rsp_status, bus.rsp_last} !== snap)) stable = 1'b0;
    end
    if (hold > 0) begin
      chk("rsp_stable", 32'(stable), 1);
      chk("no_extra_strobe", rd_cnt + wr_cnt, strobes);
    end
    bus.rsp_ready = 1'b1;
    @(negedge di_clk);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_term = '0; bus.cmd_addr = '0;
    bus.cmd_len = '0; bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rsp_ready = 1'b0;
    rd_rdy = 1'b1; wr_rdy = 1'b1; term_status = 16'h0;

    // Reset state
    repeat (3) @(negedge di_clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_ctrl", 32'({bus.di_read_mode, bus.di_read_req, bus.di_read, bus.di_write_mode,
                         bus.di_write, bus.wr_ready}), 0);
    chk("rst_reg_addr", bus.di_reg_addr, 0);
    chk("rst_term_addr", 32'(bus.di_term_addr), 0);
    resetb = 1'b1;
    @(negedge di_clk);
    chk("idle_cmd_ready", 32'(bus.cmd_ready), 1);

    // 1: single write
    clr_mon();
    bus.wr_valid = 1'b1; bus.wr_data = 32'h0000_0123;
    sb.push_back('{rdata: 32'h0, status: 16'h0, last: 1'b1});
    send_cmd(1'b1, DOT_TERM, 32'h0, 8'd0);
    get_rsp(0);
    bus.wr_valid = 1'b0;
    chk("t1_latency", lat, 4);
    chk("t1_wr_cnt", wr_cnt, 1);
    chk("t1_rd_cnt", rd_cnt, 0);
    chk("t1_datai", wr_dat_q.size() > 0 ? wr_dat_q[0] : 32'hDEAD, 32'h123);
    chk("t1_wmode_off", 32'(bus.di_write_mode), 0);

    // 2: burst read len=2 from addr 4
    clr_mon();
    sb.push_back('{rdata: 32'd8,  status: 16'h0, last: 1'b0});
    sb.push_back('{rdata: 32'd10, status: 16'h0, last: 1'b0});
    sb.push_back('{rdata: 32'd12, status: 16'h0, last: 1'b1});
    send_cmd(1'b0, DOT_TERM, 32'd4, 8'd2);
    get_rsp(0);
    chk("t2_latency", lat, 4);
    chk("t2_rmode_on", 32'(bus.di_read_mode), 1);
    get_rsp(0);
    get_rsp(0);
    chk("t2_rmode_off", 32'(bus.di_read_mode), 0);
    chk("t2_req_cnt", req_cnt, 3);
    chk("t2_rd_cnt", rd_cnt, 3);
    for (int i = 0; i < 3; i++)
      chk("t2_req_addr", req_addr_q.size() > i ? req_addr_q[i] : 32'hDEAD, 32'(4 + i));

    // 3: timeout with read_rdy low
    clr_mon();
    rd_rdy = 1'b0;
    sb.push_back('{rdata: 32'h0, status: DI_STATUS_TIMEOUT, last: 1'b1});
    send_cmd(1'b0, DOT_TERM, 32'd100, 8'd3);
    get_rsp(0);
    chk("t3_latency", lat, TIMEOUT_CYCLES + 2);  // RD_WAIT entered 2 cycles after accept
    chk("t3_rd_cnt", rd_cnt, 0);
    chk("t3_req_cnt", req_cnt, 1);
    chk("t3_rmode_off", 32'(bus.di_read_mode), 0);
    rd_rdy = 1'b1;

    // 4: terminal not enabled, read and write bursts stop after one word
    clr_mon();
    sb.push_back('{rdata: 32'h0, status: DI_STATUS_NOTERM, last: 1'b1});
    send_cmd(1'b0, 16'h7777, 32'h0, 8'd5);
    get_rsp(0);
    bus.wr_valid = 1'b1; bus.wr_data = 32'h5555;
    sb.push_back('{rdata: 32'h0, status: DI_STATUS_NOTERM, last: 1'b1});
    send_cmd(1'b1, 16'h7777, 32'h0, 8'd5);
    get_rsp(0);
    bus.wr_valid = 1'b0;
    chk("t4_rd_cnt", rd_cnt, 0);
    chk("t4_wr_cnt", wr_cnt, 0);
    chk("t4_req_cnt", req_cnt, 1);
    chk("t4_cmd_ready", 32'(bus.cmd_ready), 1);

    // terminal error status ends a burst early
    clr_mon();
    term_status = 16'h0005;
    sb.push_back('{rdata: 32'd40, status: 16'h0005, last: 1'b1});
    send_cmd(1'b0, DOT_TERM, 32'd20, 8'd3);
    get_rsp(0);
    chk("terr_req_cnt", req_cnt, 1);
    term_status = 16'h0;

    // 5: backpressure on a write burst wrapping the address
    clr_mon();
    sb.push_back('{rdata: 32'h0, status: 16'h0, last: 1'b0});
    sb.push_back('{rdata: 32'h0, status: 16'h0, last: 1'b0});
    sb.push_back('{rdata: 32'h0, status: 16'h0, last: 1'b1});
    fork
      send_cmd(1'b1, DOT_TERM, 32'hFFFF_FFFF, 8'd2);
      begin : wr_drv
        int n;
        for (int i = 0; i < 3; i++) begin
          repeat (2 + i) @(negedge di_clk);
          bus.wr_valid = 1'b1; bus.wr_data = 32'hA0 + 32'(i);
          n = 0;
          while (!bus.wr_ready && n < 200) begin @(negedge di_clk); n++; end
          chk("t5_wr_hs", 32'(bus.wr_ready), 1);
          @(negedge di_clk);
          bus.wr_valid = 1'b0;
        end
      end
      begin
        get_rsp(10);
        get_rsp(10);
        get_rsp(0);
      end
    join
    chk("t5_wr_cnt", wr_cnt, 3);
    for (int i = 0; i < 3; i++) begin
      chk("t5_wr_dat", wr_dat_q.size() > i ? wr_dat_q[i] : 32'hDEAD, 32'hA0 + 32'(i));
      chk("t5_wr_addr", wr_addr_q.size() > i ? wr_addr_q[i] : 32'hDEAD, 32'hFFFF_FFFF + 32'(i));
    end

    // 6: reset in RD_WAIT aborts silently
    clr_mon();
    rd_rdy = 1'b0;
    send_cmd(1'b0, DOT_TERM, 32'h40, 8'd3);
    repeat (4) @(negedge di_clk);
    chk("t6_in_burst", 32'(bus.di_read_mode), 1);
    resetb = 1'b0;
    #1;
    chk("t6_rst_ctrl", 32'({bus.di_read_mode, bus.di_read_req, bus.di_read, bus.di_write_mode,
                            bus.di_write, bus.rsp_valid}), 0);
    chk("t6_rst_addr", bus.di_reg_addr, 0);
    chk("t6_rst_term", 32'(bus.di_term_addr), 0);
    @(negedge di_clk);
    @(negedge di_clk);
    resetb = 1'b1;
    rd_rdy = 1'b1;
    begin : no_rsp
      logic seen;
      seen = 1'b0;
      repeat (5) begin @(negedge di_clk); if (bus.rsp_valid) seen = 1'b1; end
      chk("t6_no_rsp", 32'(seen), 0);
    end
    sb.push_back('{rdata: 32'd18, status: 16'h0, last: 1'b1});
    send_cmd(1'b0, DOT_TERM, 32'd9, 8'd0);
    get_rsp(0);
    chk("t6_latency", lat, 4);

    chk("sb_drained", sb.size(), 0);
    chk("never_both_strobes", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
